pc_fetch_stage: RTL
===================

// Module: pc_fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction-memory address and loads the IF/ID register.
//  Sits directly upstream of branch_accel. Consumes BrTaken/UncondBr/pc_rd from it, plus the ID-stage instruction, PC and register value.
//  Computes the next PC for B, BL, B.LT, CBZ and BR.
//  Implements the branch delay slot (or squash) policy, stall hold and fetch/redirect performance counters.
// PARAMETERS
//  RESET_PC   64'h0  PC value loaded on reset
//  DELAY_SLOT 1      1: instr fetched in the redirect cycle executes (valid=1); 0: it is squashed (valid=0)
//  CNT_W      32     width of performance counters
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  reset_n        in   1   asynchronous, active-low reset
//  stall          in   1   hazard-unit stall: hold PC and IF/ID
//  BrTaken        in   1   from branch_accel: PC-relative branch taken
//  UncondBr       in   1   from branch_accel: 1=imm26 (B/BL), 0=imm19 (B.LT/CBZ)
//  pc_rd          in   1   from branch_accel: BR, target = regVal_in
//  regVal_in      in   64  ID-stage register read value (BR target)
//  imem_instr     in   32  instruction memory data at address pc (combinational read)
//  pc             out  64  current fetch address to instruction memory
//  if_id_instr    out  32  IF/ID instruction register
//  if_id_pc       out  64  IF/ID PC register (PC of if_id_instr)
//  if_id_valid    out  1   IF/ID holds a real instruction
//  pc_misalign    out  1   sticky: a BR target had bits[1:0]!=0
//  fetch_cnt      out  CNT_W  number of valid instructions loaded into IF/ID
//  redirect_cnt   out  CNT_W  number of accepted redirects
// BEHAVIOUR
//  Reset (reset_n=0, async): pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, pc_misalign=0, counters=0, state=BOOT.
//  FSM: BOOT -> RUN on first posedge after reset release (unconditional, stall ignored in BOOT); RUN persists until reset.
//   BOOT edge: IF/ID <= {imem_instr, pc}, valid=1, pc <= pc+4, fetch_cnt+1.
//  redirect = (BrTaken | pc_rd) & if_id_valid & ~stall & state==RUN. Branch signals are ignored when ID holds a bubble.
//  Target select: pc_rd has priority over BrTaken.
//   pc_rd: target = {regVal_in[63:2],2'b00}; if regVal_in[1:0]!=0 then pc_misalign<=1 (sticky).
//   BrTaken&UncondBr: target = if_id_pc + (sext64(if_id_instr[25:0])<<2).
//   BrTaken&~UncondBr: target = if_id_pc + (sext64(if_id_instr[23:5])<<2).
//   Addition is modulo 2^64 and wraps silently.
//  Per RUN posedge:
//   stall=1: pc, IF/ID, counters hold. Branch inputs are ignored; ID is held, so the branch re-evaluates next cycle.
//   redirect: pc <= target; IF/ID <= {imem_instr, pc}; if_id_valid <= DELAY_SLOT; redirect_cnt+1; fetch_cnt+DELAY_SLOT.
//   otherwise: pc <= pc+4; IF/ID <= {imem_instr, pc}, valid=1; fetch_cnt+1.
//  Branch in the delay slot (DELAY_SLOT=1): it is a valid ID instruction and redirects normally next cycle.
//  Back-to-back branches with DELAY_SLOT=0: the second is a squashed bubble and never redirects.
//  Latency: redirect takes effect on the pc one edge after the branch is in ID. The penalty is one slot (delay slot or bubble).
//  Counters wrap modulo 2^CNT_W. Reset mid-operation immediately returns all state to reset values.
//  pc is only ever word aligned (bits[1:0]=0).
// TESTING
//  1. Reset release, imem returns 0x91000421 at every address, no branch.
//     -> 1st edge if_id_pc=0, valid=1; pc steps 4,8,C each cycle; fetch_cnt=3 after 3 edges.
//  2. if_id_pc=0x40, if_id_instr=B imm26=-2 (0x17FFFFFE), BrTaken=1, UncondBr=1.
//     -> pc=0x38 next edge; DELAY_SLOT=1: slot instr valid; redirect_cnt=1.
//  3. CBZ at if_id_pc=0x100, imm19=+5, BrTaken=1, UncondBr=0, stall=1 for 2 cycles, then 0.
//     -> pc/IF/ID frozen 2 cycles, then pc=0x114.
//  4. pc_rd=1, regVal_in=0x2003.
//     -> pc=0x2000, pc_misalign=1 and remains 1 until reset_n=0.
//  5. DELAY_SLOT=0, two consecutive taken B instructions.
//     -> first redirects and slot valid=0; second ignored; redirect_cnt=1, fetch_cnt excludes squashed slot.
//  6. reset_n pulsed low mid-redirect.
//     -> pc=RESET_PC, valid=0, counters 0 asynchronously; BOOT sequence repeats.

Source files
------------

// File: rtl/pc_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage_if
// Purpose : bundles the fetch-stage datapath signals exchanged with the
//           hazard unit, branch_accel, the ID stage and instruction memory.
// Signals :
//   stall        hazard-unit stall, hold PC and IF/ID
//   BrTaken      PC-relative branch taken (from branch_accel)
//   UncondBr     1 = imm26 (B/BL), 0 = imm19 (B.LT/CBZ)
//   pc_rd        register-indirect branch (BR), target from regVal_in
//   regVal_in    ID-stage register read value (BR target)
//   imem_instr   instruction memory data at address pc
//   pc           current fetch address
//   if_id_instr  IF/ID instruction register
//   if_id_pc     IF/ID PC register
//   if_id_valid  IF/ID holds a real instruction
//   pc_misalign  sticky flag, a BR target had bits[1:0] != 0
//   fetch_cnt    valid instructions loaded into IF/ID
//   redirect_cnt accepted redirects
// Modports: master = fetch stage, slave = its environment.
// ---------------------------------------------------------------------------
interface pc_fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             BrTaken;
    logic             UncondBr;
    logic             pc_rd;
    logic [63:0]      regVal_in;
    logic [31:0]      imem_instr;
    logic [63:0]      pc;
    logic [31:0]      if_id_instr;
    logic [63:0]      if_id_pc;
    logic             if_id_valid;
    logic             pc_misalign;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        input  stall, BrTaken, UncondBr, pc_rd, regVal_in, imem_instr,
        output pc, if_id_instr, if_id_pc, if_id_valid, pc_misalign,
               fetch_cnt, redirect_cnt
    );

    modport slave (
        output stall, BrTaken, UncondBr, pc_rd, regVal_in, imem_instr,
        input  pc, if_id_instr, if_id_pc, if_id_valid, pc_misalign,
               fetch_cnt, redirect_cnt
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
// Purpose : instruction-fetch stage. Owns the PC, drives the instruction
//           memory address, loads the IF/ID register and computes the next
//           PC for B, BL, B.LT, CBZ and BR. The instruction fetched in the
//           redirect cycle either executes (DELAY_SLOT=1) or becomes a
//           bubble (DELAY_SLOT=0). Keeps fetch / redirect counters.
// Ports   :
//   clk      in  clock, all state updates on posedge
//   reset_n  in  asynchronous active-low reset
//   bus      pc_fetch_stage_if.master, see the interface for signal list
// Parameters:
//   RESET_PC    PC loaded on reset
//   DELAY_SLOT  1: redirect-cycle instruction valid, 0: squashed
//   CNT_W       performance counter width (must match the interface)
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int          CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pc_fetch_stage_if.master      bus
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [63:0]      r_pc;
    logic [31:0]      r_if_id_instr;
    logic [63:0]      r_if_id_pc;
    logic             r_if_id_valid;
    logic             r_pc_misalign;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_redirect_cnt;

    state_t           w_state_nx;
    logic [63:0]      w_pc_nx;
    logic [31:0]      w_if_id_instr_nx;
    logic [63:0]      w_if_id_pc_nx;
    logic             w_if_id_valid_nx;
    logic             w_pc_misalign_nx;
    logic [CNT_W-1:0] w_fetch_cnt_nx;
    logic [CNT_W-1:0] w_redirect_cnt_nx;

    logic             w_redirect;
    logic [63:0]      w_br_off;
    logic [63:0]      w_target;

    // A branch in ID only counts when ID holds a real instruction; a
    // squashed slot therefore can never redirect.
    assign w_redirect = (bus.BrTaken | bus.pc_rd) & r_if_id_valid
                      & ~bus.stall & (r_state == ST_RUN);

    // Word offsets sign-extended to 64 bits and scaled by 4.
    assign w_br_off = bus.UncondBr
                    ? {{36{r_if_id_instr[25]}}, r_if_id_instr[25:0], 2'b00}
                    : {{43{r_if_id_instr[23]}}, r_if_id_instr[23:5], 2'b00};

    // BR has priority; its target is forced word aligned so pc stays aligned.
    assign w_target = bus.pc_rd ? {bus.regVal_in[63:2], 2'b00}
                                : r_if_id_pc + w_br_off;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_nx        = r_state;
        w_pc_nx           = r_pc;
        w_if_id_instr_nx  = r_if_id_instr;
        w_if_id_pc_nx     = r_if_id_pc;
        w_if_id_valid_nx  = r_if_id_valid;
        w_pc_misalign_nx  = r_pc_misalign;
        w_fetch_cnt_nx    = r_fetch_cnt;
        w_redirect_cnt_nx = r_redirect_cnt;

        unique case (r_state)
            ST_BOOT: begin
                // First edge out of reset always fetches, stall or not.
                w_state_nx       = ST_RUN;
                w_pc_nx          = r_pc + 64'd4;
                w_if_id_instr_nx = bus.imem_instr;
                w_if_id_pc_nx    = r_pc;
                w_if_id_valid_nx = 1'b1;
                w_fetch_cnt_nx   = r_fetch_cnt + CNT_W'(1);
            end
            ST_RUN: begin
                if (w_redirect) begin
                    w_pc_nx           = w_target;
                    w_if_id_instr_nx  = bus.imem_instr;
                    w_if_id_pc_nx     = r_pc;
                    w_if_id_valid_nx  = DELAY_SLOT;
                    w_fetch_cnt_nx    = r_fetch_cnt + CNT_W'(DELAY_SLOT);
                    w_redirect_cnt_nx = r_redirect_cnt + CNT_W'(1);
                    if (bus.pc_rd && (bus.regVal_in[1:0] != 2'b00)) begin
                        w_pc_misalign_nx = 1'b1;
                    end
                end else if (!bus.stall) begin
                    w_pc_nx          = r_pc + 64'd4;
                    w_if_id_instr_nx = bus.imem_instr;
                    w_if_id_pc_nx    = r_pc;
                    w_if_id_valid_nx = 1'b1;
                    w_fetch_cnt_nx   = r_fetch_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = ST_BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_PC;
            r_if_id_instr  <= '0;
            r_if_id_pc     <= '0;
            r_if_id_valid  <= 1'b0;
            r_pc_misalign  <= 1'b0;
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_pc           <= w_pc_nx;
            r_if_id_instr  <= w_if_id_instr_nx;
            r_if_id_pc     <= w_if_id_pc_nx;
            r_if_id_valid  <= w_if_id_valid_nx;
            r_pc_misalign  <= w_pc_misalign_nx;
            r_fetch_cnt    <= w_fetch_cnt_nx;
            r_redirect_cnt <= w_redirect_cnt_nx;
        end
    end

    assign bus.pc           = r_pc;
    assign bus.if_id_instr  = r_if_id_instr;
    assign bus.if_id_pc     = r_if_id_pc;
    assign bus.if_id_valid  = r_if_id_valid;
    assign bus.pc_misalign  = r_pc_misalign;
    assign bus.fetch_cnt    = r_fetch_cnt;
    assign bus.redirect_cnt = r_redirect_cnt;

endmodule
